// File: rtl/axi_lite_regfile_slave.sv
// AXI4-Lite slave exposing NUM_REGS byte-strobed read/write registers.
// Define AXIL_REGFILE_DECERR_EN to answer out-of-range accesses with SLVERR.
module axi_lite_regfile_slave #(
   parameter int unsigned           DATA_WIDTH  = 32,
   parameter int unsigned           ADDR_WIDTH  = 11,
   parameter int unsigned           NUM_REGS    = 16,
   parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic                           awvalid,
   output logic                           awready,
   input  logic [ADDR_WIDTH-1:0]          awaddr,
   input  logic [2:0]                     awprot,
   input  logic                           wvalid,
   output logic                           wready,
   input  logic [DATA_WIDTH-1:0]          wdata,
   input  logic [DATA_WIDTH/8-1:0]        wstrb,
   output logic                           bvalid,
   input  logic                           bready,
   output logic [1:0]                     bresp,
   input  logic                           arvalid,
   output logic                           arready,
   input  logic [ADDR_WIDTH-1:0]          araddr,
   input  logic [2:0]                     arprot,
   output logic                           rvalid,
   input  logic                           rready,
   output logic [DATA_WIDTH-1:0]          rdata,
   output logic [1:0]                     rresp,
   output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
   output logic [NUM_REGS-1:0]            reg_wr_pulse
);
   localparam int unsigned STRB_W = DATA_WIDTH / 8;
   localparam int unsigned OFF    = $clog2(STRB_W);
   localparam int unsigned IDX_W  = ADDR_WIDTH - OFF;

   typedef enum logic {W_IDLE, W_RESP} wstate_e;
   typedef enum logic {R_IDLE, R_DATA} rstate_e;

   wstate_e               wstate_q;
   rstate_e               rstate_q;
   logic                  aw_have_q, w_have_q;
   logic [IDX_W-1:0]      aw_idx_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [STRB_W-1:0]     wstrb_q;
   logic                  awready_q, wready_q, bvalid_q;
   logic                  arready_q, rvalid_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic [NUM_REGS-1:0]   pulse_q;
   logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

   logic                  aw_hs, w_hs, ar_hs, commit;
   logic [IDX_W-1:0]      wr_idx, rd_idx;
   logic [DATA_WIDTH-1:0] wr_data, rd_word;
   logic [STRB_W-1:0]     wr_strb;
   logic                  unused_ok;

   assign aw_hs   = awvalid & awready_q;
   assign w_hs    = wvalid & wready_q;
   assign ar_hs   = arvalid & arready_q;
   assign commit  = (wstate_q == W_IDLE) & (aw_have_q | aw_hs)
                  & (w_have_q | w_hs);
   // A channel accepted this very cycle bypasses its holding register.
   assign wr_idx  = aw_have_q ? aw_idx_q : awaddr[ADDR_WIDTH-1:OFF];
   assign wr_data = w_have_q ? wdata_q : wdata;
   assign wr_strb = w_have_q ? wstrb_q : wstrb;
   assign rd_idx  = araddr[ADDR_WIDTH-1:OFF];

   assign unused_ok = ^{awprot, arprot, awaddr[OFF-1:0], araddr[OFF-1:0]};

   always_comb begin
      rd_word = '0;
      for (int unsigned r = 0; r < NUM_REGS; r++)
         if (rd_idx == IDX_W'(r)) rd_word = regs_q[r];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned r = 0; r < NUM_REGS; r++) regs_q[r] <= RESET_VALUE;
         pulse_q <= '0;
      end else begin
         pulse_q <= '0;
         if (commit) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
               if (wr_idx == IDX_W'(r)) begin
                  pulse_q[r] <= 1'b1;
                  for (int unsigned b = 0; b < STRB_W; b++)
                     if (wr_strb[b]) regs_q[r][8*b +: 8] <= wr_data[8*b +: 8];
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wstate_q  <= W_IDLE;
         aw_have_q <= 1'b0;
         w_have_q  <= 1'b0;
         aw_idx_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
      end else begin
         case (wstate_q)
            W_IDLE: begin
               if (commit) begin
                  wstate_q  <= W_RESP;
                  aw_have_q <= 1'b0;
                  w_have_q  <= 1'b0;
                  awready_q <= 1'b0;
                  wready_q  <= 1'b0;
                  bvalid_q  <= 1'b1;
               end else begin
                  if (aw_hs) begin
                     aw_have_q <= 1'b1;
                     aw_idx_q  <= awaddr[ADDR_WIDTH-1:OFF];
                  end
                  if (w_hs) begin
                     w_have_q <= 1'b1;
                     wdata_q  <= wdata;
                     wstrb_q  <= wstrb;
                  end
                  awready_q <= !(aw_have_q | aw_hs);
                  wready_q  <= !(w_have_q | w_hs);
               end
            end
            W_RESP: begin
               if (bready) begin
                  wstate_q  <= W_IDLE;
                  bvalid_q  <= 1'b0;
                  awready_q <= 1'b1;
                  wready_q  <= 1'b1;
               end
            end
            default: wstate_q <= W_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rstate_q  <= R_IDLE;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
      end else begin
         case (rstate_q)
            R_IDLE: begin
               if (ar_hs) begin
                  rstate_q  <= R_DATA;
                  arready_q <= 1'b0;
                  rvalid_q  <= 1'b1;
                  rdata_q   <= rd_word;
               end else begin
                  arready_q <= 1'b1;
               end
            end
            R_DATA: begin
               if (rready) begin
                  rstate_q  <= R_IDLE;
                  rvalid_q  <= 1'b0;
                  arready_q <= 1'b1;
               end
            end
            default: rstate_q <= R_IDLE;
         endcase
      end
   end

`ifdef AXIL_REGFILE_DECERR_EN
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   logic [1:0] bresp_q, rresp_q;
   logic       wr_in_range, rd_in_range;

   assign wr_in_range = 32'(wr_idx) < NUM_REGS;
   assign rd_in_range = 32'(rd_idx) < NUM_REGS;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bresp_q <= RESP_OKAY;
         rresp_q <= RESP_OKAY;
      end else begin
         if (commit) bresp_q <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
         if (ar_hs)  rresp_q <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
      end
   end

   assign bresp = bresp_q;
   assign rresp = rresp_q;
`else
   assign bresp = 2'b00;
   assign rresp = 2'b00;
`endif

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
      assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
   end

   assign awready      = awready_q;
   assign wready       = wready_q;
   assign bvalid       = bvalid_q;
   assign arready      = arready_q;
   assign rvalid       = rvalid_q;
   assign rdata        = rdata_q;
   assign reg_wr_pulse = pulse_q;
endmodule

// File: tb/tb_axi_lite_regfile_slave.sv
// Directed testbench for axi_lite_regfile_slave.
// Expected out-of-range responses follow AXIL_REGFILE_DECERR_EN.
module tb_axi_lite_regfile_slave;
   localparam int          DW = 32;
   localparam int          AW = 11;
   localparam int          NR = 16;
   localparam logic [31:0] RV = 32'hA5A5_0000;
`ifdef AXIL_REGFILE_DECERR_EN
   localparam logic [1:0]  OOR_RESP = 2'b10;
`else
   localparam logic [1:0]  OOR_RESP = 2'b00;
`endif

   logic             clk = 1'b0;
   logic             reset_n;
   logic             awvalid, awready, wvalid, wready;
   logic [AW-1:0]    awaddr, araddr;
   logic [2:0]       awprot, arprot;
   logic [DW-1:0]    wdata, rdata;
   logic [DW/8-1:0]  wstrb;
   logic             bvalid, bready, arvalid, arready, rvalid, rready;
   logic [1:0]       bresp, rresp;
   logic [NR*DW-1:0] reg_q;
   logic [NR-1:0]    reg_wr_pulse;

   int          n_chk  = 0;
   int          n_fail = 0;
   logic [31:0] model [NR];
   logic [1:0]  resp;
   logic [15:0] pulse;
   logic [31:0] data;

   axi_lite_regfile_slave #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR), .RESET_VALUE(RV)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
      .bvalid(bvalid), .bready(bready), .bresp(bresp),
      .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
      .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
      .reg_q(reg_q), .reg_wr_pulse(reg_wr_pulse)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] word(input int i);
      return reg_q[i*DW +: DW];
   endfunction

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_b(output logic [1:0] r, output logic [15:0] p);
      bit got = 0;
      bready = 1'b1;
      r = '0;
      p = '0;
      for (int n = 0; n < 50 && !got; n++) begin
         @(negedge clk);
         if (bvalid) begin
            got = 1;
            r = bresp;
            p = reg_wr_pulse;
         end
         @(posedge clk); #1;
      end
      bready = 1'b0;
      check("b_seen", got, 1);
   endtask

   task automatic axi_write(input logic [10:0] a, input logic [31:0] d,
                            input logic [3:0] s, output logic [1:0] r,
                            output logic [15:0] p);
      bit a_done = 0, w_done = 0, a_ok, w_ok;
      @(posedge clk); #1;
      awvalid = 1'b1; awaddr = a;
      wvalid = 1'b1; wdata = d; wstrb = s;
      for (int n = 0; n < 50 && !(a_done && w_done); n++) begin
         @(negedge clk);
         a_ok = awvalid && awready;
         w_ok = wvalid && wready;
         @(posedge clk); #1;
         if (a_ok) begin awvalid = 1'b0; a_done = 1; end
         if (w_ok) begin wvalid = 1'b0; w_done = 1; end
      end
      check("aw_w_accept", {a_done, w_done}, 2'b11);
      wait_b(r, p);
   endtask

   task automatic axi_read(input logic [10:0] a, output logic [31:0] d,
                           output logic [1:0] r);
      bit a_done = 0, got = 0, a_ok;
      d = '0;
      r = '0;
      @(posedge clk); #1;
      arvalid = 1'b1; araddr = a; rready = 1'b1;
      for (int n = 0; n < 50 && !a_done; n++) begin
         @(negedge clk);
         a_ok = arready;
         @(posedge clk); #1;
         if (a_ok) begin arvalid = 1'b0; a_done = 1; end
      end
      for (int n = 0; n < 50 && !got; n++) begin
         @(negedge clk);
         if (rvalid) begin got = 1; d = rdata; r = rresp; end
         @(posedge clk); #1;
      end
      rready = 1'b0;
      check("ar_accept", a_done, 1);
      check("r_seen", got, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0;
      awvalid = 0; awaddr = '0; awprot = '0;
      wvalid = 0; wdata = '0; wstrb = '0; bready = 0;
      arvalid = 0; araddr = '0; arprot = '0; rready = 0;
      for (int i = 0; i < NR; i++) model[i] = RV;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_readies", {awready, wready, arready}, 3'b000);
      check("rst_valids", {bvalid, rvalid}, 2'b00);
      check("rst_resps", {bresp, rresp}, 4'h0);
      check("rst_rdata", rdata, 0);
      check("rst_pulse", reg_wr_pulse, 0);
      check("rst_reg0", word(0), RV);
      check("rst_reg15", word(15), RV);
      reset_n = 1'b1;
      @(negedge clk);
      check("post_rst_readies", {awready, wready, arready}, 3'b111);

      // AW first, W three cycles later
      @(posedge clk); #1;
      awvalid = 1'b1; awaddr = 11'h008;
      @(negedge clk);
      check("aw_ready_idle", awready, 1);
      @(posedge clk); #1;
      awvalid = 1'b0;
      @(negedge clk);
      check("aw_ready_latched", awready, 0);
      check("w_ready_open", wready, 1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      wvalid = 1'b1; wdata = 32'h1234_5678; wstrb = 4'hF;
      @(negedge clk);
      check("reg2_pre_commit", word(2), RV);
      @(posedge clk); #1;
      wvalid = 1'b0;
      model[2] = 32'h1234_5678;
      @(negedge clk);
      check("reg2_commit", word(2), model[2]);
      check("pulse_reg2", reg_wr_pulse, 16'h0004);
      check("bvalid_after_commit", bvalid, 1);
      check("bresp_okay", bresp, 2'b00);

      // bready low for 10 cycles with a new AW waiting
      @(posedge clk); #1;
      awvalid = 1'b1; awaddr = 11'h014;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("hold_bvalid", bvalid, 1);
         check("hold_readies", {awready, wready}, 2'b00);
         if (i == 0) check("pulse_one_cycle", reg_wr_pulse, 0);
         @(posedge clk); #1;
      end
      bready = 1'b1;
      @(negedge clk);
      check("bvalid_at_hs", bvalid, 1);
      @(posedge clk); #1;
      bready = 1'b0;
      @(negedge clk);
      check("bvalid_dropped", bvalid, 0);
      check("aw_reopen", awready, 1);
      @(posedge clk); #1;
      awvalid = 1'b0;
      @(negedge clk);
      check("aw_taken_after_b", awready, 0);
      @(posedge clk); #1;
      wvalid = 1'b1; wdata = 32'h0000_00AB; wstrb = 4'b0001;
      @(posedge clk); #1;
      wvalid = 1'b0;
      model[5] = 32'hA5A5_00AB;
      wait_b(resp, pulse);
      check("pulse_reg5", pulse, 16'h0020);
      check("reg5_byte0", word(5), model[5]);

      // Byte strobes on register 1
      axi_write(11'h004, 32'h0000_0000, 4'hF, resp, pulse);
      check("pulse_reg1", pulse, 16'h0002);
      axi_write(11'h004, 32'hFFFF_FFFF, 4'b0101, resp, pulse);
      model[1] = 32'h00FF_00FF;
      check("reg1_strobe", word(1), model[1]);
      axi_read(11'h004, data, resp);
      check("rd_reg1", data, model[1]);
      check("rd_reg1_resp", resp, 2'b00);

      // Top register, upper byte only; low offset bits ignored
      axi_write(11'h03F, 32'h7700_0000, 4'b1000, resp, pulse);
      model[15] = 32'h77A5_0000;
      check("pulse_reg15", pulse, 16'h8000);
      axi_read(11'h03C, data, resp);
      check("rd_reg15", data, model[15]);

      // Read/write collision on register 3
      axi_write(11'h00C, 32'h1111_1111, 4'hF, resp, pulse);
      @(posedge clk); #1;
      awvalid = 1'b1; awaddr = 11'h00C;
      wvalid = 1'b1; wdata = 32'hDEAD_BEEF; wstrb = 4'hF;
      arvalid = 1'b1; araddr = 11'h00C;
      @(negedge clk);
      check("coll_readies", {awready, wready, arready}, 3'b111);
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      bready = 1'b1; rready = 1'b1;
      model[3] = 32'hDEAD_BEEF;
      @(negedge clk);
      check("coll_rvalid", rvalid, 1);
      check("coll_old_value", rdata, 32'h1111_1111);
      check("coll_bvalid", bvalid, 1);
      check("coll_reg3", word(3), model[3]);
      @(posedge clk); #1;
      bready = 1'b0; rready = 1'b0;
      axi_read(11'h00C, data, resp);
      check("rd_reg3_new", data, model[3]);

      // Out-of-range access
      axi_write(11'h044, 32'hCAFE_F00D, 4'hF, resp, pulse);
      check("oor_bresp", resp, OOR_RESP);
      check("oor_no_pulse", pulse, 0);
      for (int i = 0; i < NR; i++) check("oor_reg_keep", word(i), model[i]);
      axi_read(11'h044, data, resp);
      check("oor_rdata", data, 0);
      check("oor_rresp", resp, OOR_RESP);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
